// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
// Buffers golden nonces coming out of the hashing pipeline until the host
// readout logic collects them over a valid/ready port. A back-to-back repeat
// filter drops the same nonce reported twice in a row. The hasher cannot be
// stalled, so candidates arriving at a full queue are counted as overflow
// instead of being held back.

module golden_nonce_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [31:0]           in_nonce,
  output logic                  out_valid,
  output logic [31:0]           out_nonce,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [OVF_WIDTH-1:0]  overflow_count,
  output logic [7:0]            dup_count
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Storage; never cleared, since the pointers and level define what is live.
  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [31:0]           lastNonce_q, lastNonce_d;
  logic                  lastValid_q, lastValid_d;
  logic [OVF_WIDTH-1:0]  ovfCount_q, ovfCount_d;
  logic [7:0]            dupCount_q, dupCount_d;
  logic [31:0]           outNonce_q, outNonce_d;

  logic isDup;
  logic push;
  logic pop;
  logic isFull;
  logic doWrite;
  logic dropped;
  logic memWrEn;

  // Classify this cycle's candidate and decide whether it lands in the
  // buffer, gets dropped for overflow, or is filtered as a repeat.
  always_comb begin
    isDup   = in_valid && lastValid_q && (in_nonce == lastNonce_q);
    push    = in_valid && !isDup;
    pop     = (level_q != '0) && out_ready;
    isFull  = (level_q == FULL_LEVEL);
    // A full queue still accepts a push when the head leaves in the same cycle.
    doWrite = push && (!isFull || pop);
    dropped = push && isFull && !pop;
    memWrEn = doWrite && !flush;
  end

  // Next-state for pointers, level, filter, counters and the registered head.
  // A flush discards everything in flight, including this cycle's candidate
  // and any pop offered alongside it.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    lastNonce_d = lastNonce_q;
    lastValid_d = lastValid_q;
    ovfCount_d  = ovfCount_q;
    dupCount_d  = dupCount_q;
    outNonce_d  = outNonce_q;

    if (flush) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      level_d     = '0;
      lastValid_d = 1'b0;
      ovfCount_d  = '0;
      dupCount_d  = '0;
      outNonce_d  = '0;
    end else begin
      if (doWrite) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_ONE;
      end

      case ({doWrite, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase

      // Every fresh candidate becomes the new reference for the repeat
      // filter, even one that is about to be lost to overflow.
      if (push) begin
        lastNonce_d = in_nonce;
        lastValid_d = 1'b1;
      end

      if (isDup && (dupCount_q != 8'hFF)) begin
        dupCount_d = dupCount_q + 8'd1;
      end

      if (dropped && (ovfCount_q != '1)) begin
        ovfCount_d = ovfCount_q + {{(OVF_WIDTH-1){1'b0}}, 1'b1};
      end

      // Preload the head register with whatever sits at the next read
      // pointer, forwarding the incoming word when it is being written
      // into that very slot (empty queue, first word).
      if (level_d != '0) begin
        if (doWrite && (wrPtr_q == rdPtr_d)) begin
          outNonce_d = in_nonce;
        end else begin
          outNonce_d = mem[rdPtr_d];
        end
      end
    end
  end

  // Buffer write port.
  always_ff @(posedge hash_clk) begin
    if (memWrEn && !reset) begin
      mem[wrPtr_q] <= in_nonce;
    end
  end

  // State register; reset clears the same state as flush and zeroes the head.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      lastNonce_q <= '0;
      lastValid_q <= 1'b0;
      ovfCount_q  <= '0;
      dupCount_q  <= '0;
      outNonce_q  <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      lastNonce_q <= lastNonce_d;
      lastValid_q <= lastValid_d;
      ovfCount_q  <= ovfCount_d;
      dupCount_q  <= dupCount_d;
      outNonce_q  <= outNonce_d;
    end
  end

  assign out_valid      = (level_q != '0);
  assign out_nonce      = outNonce_q;
  assign level          = level_q;
  assign overflow_count = ovfCount_q;
  assign dup_count      = dupCount_q;

endmodule
